// File: rtl/cv32e40p_fault_pkg.sv
// Shared types and helpers for the cv32e40p fault monitor.
// Event classes, FSM states, read selects and status word layout.
package cv32e40p_fault_pkg;

  localparam int NCLS = 5;

  typedef enum logic [2:0] {
    CLS_DIV  = 3'd0,
    CLS_MEM  = 3'd1,
    CLS_ECC  = 3'd2,
    CLS_MULT = 3'd3,
    CLS_CS   = 3'd4
  } fault_cls_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ALARM = 1'b1
  } fault_state_e;

  localparam logic [2:0] SEL_STAT  = 3'd5;
  localparam logic [2:0] SEL_TS_LO = 3'd6;
  localparam logic [2:0] SEL_TS_HI = 3'd7;

  localparam int STAT_FATAL   = 15;
  localparam int STAT_VALID   = 14;
  localparam int STAT_CLS_LSB = 5;

  function automatic logic [32:0] maj3(
    input logic [32:0] a,
    input logic [32:0] b,
    input logic [32:0] c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic [2:0] first_cls(
    input logic [4:0] ev
  );
    first_cls = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (ev[i]) first_cls = 3'(i);
    end
  endfunction

endpackage

// File: rtl/cv32e40p_fault_counter.sv
// Saturating event counter for one fault class.
// A clear and an increment in the same cycle leave the counter at one.
module cv32e40p_fault_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [CNT_W-1:0] nxt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] base;

  always_comb begin
    base  = clr_i ? '0 : cnt_q;
    cnt_d = base;
    if (inc_i && (base != '1)) begin
      cnt_d = base + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign nxt_o = cnt_d;

endmodule

// File: rtl/cv32e40p_fault_monitor.sv
// Fault monitor: votes divider lanes, counts/classifies TMR errors,
// keeps sticky status, first-error record and alarm/ack handshake.
module cv32e40p_fault_monitor
  import cv32e40p_fault_pkg::*;
#(
  parameter int               CNT_W           = 16,
  parameter logic [CNT_W-1:0] FATAL_THRESHOLD = 16'd8,
  parameter int               TS_W            = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [32:0] div_out_0_i,
  input  logic [32:0] div_out_1_i,
  input  logic [32:0] div_out_2_i,
  input  logic [14:0] mem_err_i,
  input  logic [2:0]  ecc_err_i,
  input  logic [8:0]  tmr_mult_err_i,
  input  logic        cs_error_i,
  input  logic        clr_i,
  input  logic        alarm_ack_i,
  input  logic [2:0]  rd_sel_i,
  output logic [32:0] div_voted_o,
  output logic        alarm_o,
  output logic        fatal_o,
  output logic [15:0] rd_data_o
);

  // Stage 1: clr/ack travel with the error flags so that
  // "same cycle" means the same input cycle for all of them.
  logic [32:0]     l0_q, l1_q, l2_q;
  logic [14:0]     mem_q;
  logic [2:0]      ecc_q;
  logic [8:0]      mult_q;
  logic            cs_q, clr_q, ack_q;
  logic [TS_W-1:0] ts1_q;
  logic [TS_W-1:0] ts_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      l0_q   <= '0;
      l1_q   <= '0;
      l2_q   <= '0;
      mem_q  <= '0;
      ecc_q  <= '0;
      mult_q <= '0;
      cs_q   <= 1'b0;
      clr_q  <= 1'b0;
      ack_q  <= 1'b0;
      ts1_q  <= '0;
      ts_q   <= '0;
      div_voted_o <= '0;
    end else begin
      l0_q   <= div_out_0_i;
      l1_q   <= div_out_1_i;
      l2_q   <= div_out_2_i;
      mem_q  <= mem_err_i;
      ecc_q  <= ecc_err_i;
      mult_q <= tmr_mult_err_i;
      cs_q   <= cs_error_i;
      clr_q  <= clr_i;
      ack_q  <= alarm_ack_i;
      ts1_q  <= ts_q;
      ts_q   <= ts_q + TS_W'(1);
      div_voted_o <= maj3(div_out_0_i, div_out_1_i, div_out_2_i);
    end
  end

  logic [4:0] ev;
  logic       any_ev;
  logic       unc;

  always_comb begin
    ev = '0;
    ev[CLS_DIV]  = (l0_q != l1_q) || (l1_q != l2_q);
    ev[CLS_MEM]  = |mem_q;
    ev[CLS_ECC]  = |ecc_q;
    ev[CLS_MULT] = |mult_q;
    ev[CLS_CS]   = cs_q;
    any_ev = |ev;
    unc = (l0_q != l1_q) && (l1_q != l2_q) && (l0_q != l2_q);
  end

  logic [CNT_W-1:0] cnt [NCLS];
  logic [CNT_W-1:0] nxt [NCLS];

  for (genvar g = 0; g < NCLS; g++) begin : g_cnt
    cv32e40p_fault_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (clr_q),
      .inc_i (ev[g]),
      .cnt_o (cnt[g]),
      .nxt_o (nxt[g])
    );
  end

  logic            hit;
  logic [4:0]      status_q, status_d;
  logic            rec_valid_q, rec_valid_d;
  logic [2:0]      rec_cls_q, rec_cls_d;
  logic [TS_W-1:0] rec_ts_q, rec_ts_d;
  logic            fatal_q, fatal_d;
  fault_state_e    state_q, state_d;

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < NCLS; i++) begin
      if (nxt[i] >= FATAL_THRESHOLD) hit = 1'b1;
    end
    status_d    = (clr_q ? 5'd0 : status_q) | ev;
    rec_valid_d = clr_q ? 1'b0 : rec_valid_q;
    rec_cls_d   = clr_q ? 3'd0 : rec_cls_q;
    rec_ts_d    = clr_q ? '0 : rec_ts_q;
    if (any_ev && !rec_valid_d) begin
      rec_valid_d = 1'b1;
      rec_cls_d   = first_cls(ev);
      rec_ts_d    = ts1_q;
    end
    fatal_d = (clr_q ? 1'b0 : fatal_q)
            | hit | ev[CLS_CS] | unc;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (any_ev) state_d = ST_ALARM;
      ST_ALARM: if (ack_q && !any_ev) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  logic [15:0] stat_word;
  logic [15:0] rd_d;

  always_comb begin
    stat_word = '0;
    stat_word[STAT_FATAL] = fatal_q;
    stat_word[STAT_VALID] = rec_valid_q;
    stat_word[STAT_CLS_LSB +: 3] = rec_cls_q;
    stat_word[4:0] = status_q;
    rd_d = '0;
    unique case (rd_sel_i)
      SEL_STAT:  rd_d = stat_word;
      SEL_TS_LO: rd_d = rec_ts_q[15:0];
      SEL_TS_HI: rd_d = rec_ts_q[31:16];
      default:   rd_d = cnt[rd_sel_i];
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      status_q    <= '0;
      rec_valid_q <= 1'b0;
      rec_cls_q   <= '0;
      rec_ts_q    <= '0;
      fatal_q     <= 1'b0;
      state_q     <= ST_IDLE;
      rd_data_o   <= '0;
    end else begin
      status_q    <= status_d;
      rec_valid_q <= rec_valid_d;
      rec_cls_q   <= rec_cls_d;
      rec_ts_q    <= rec_ts_d;
      fatal_q     <= fatal_d;
      state_q     <= state_d;
      rd_data_o   <= rd_d;
    end
  end

  assign alarm_o = (state_q == ST_ALARM);
  assign fatal_o = fatal_q;

endmodule

// File: tb/tb_cv32e40p_fault_monitor.sv
// Scoreboard bench for cv32e40p_fault_monitor with a cycle-level model.
// Driver pushes expected outputs; a monitor pops and compares each cycle.
module tb_cv32e40p_fault_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic [32:0] d0, d1, d2;
  logic [14:0] mem;
  logic [2:0]  ecc;
  logic [8:0]  mult;
  logic        cs, clr, ack;
  logic [2:0]  sel;
  logic [32:0] voted;
  logic        alarm, fatal;
  logic [15:0] rd;

  always #5 clk = ~clk;

  cv32e40p_fault_monitor dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .div_out_0_i    (d0),
    .div_out_1_i    (d1),
    .div_out_2_i    (d2),
    .mem_err_i      (mem),
    .ecc_err_i      (ecc),
    .tmr_mult_err_i (mult),
    .cs_error_i     (cs),
    .clr_i          (clr),
    .alarm_ack_i    (ack),
    .rd_sel_i       (sel),
    .div_voted_o    (voted),
    .alarm_o        (alarm),
    .fatal_o        (fatal),
    .rd_data_o      (rd)
  );

  typedef struct {
    logic [32:0] voted;
    bit          alarm;
    bit          fatal;
    logic [15:0] rd;
  } exp_t;

  typedef struct {
    logic [32:0] l0, l1, l2;
    bit          mem, ecc, mult, cs, clr, ack;
    bit [31:0]   ts;
  } pend_t;

  exp_t  q[$];
  int    checks = 0;
  int    failures = 0;

  int unsigned m_cnt[5];
  bit [4:0]    m_st;
  bit          m_rv, m_fat, m_alm;
  bit [2:0]    m_rc;
  bit [31:0]   m_rts, m_ts;
  pend_t       m_p;

  task automatic chk(input string n, input logic [63:0] a,
                     input logic [63:0] r);
    checks++;
    if (a !== r) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, a, r);
    end
  endtask

  function automatic logic [32:0] vote(input logic [32:0] a,
                                       input logic [32:0] b,
                                       input logic [32:0] c);
    logic [32:0] v;
    for (int i = 0; i < 33; i++) begin
      v[i] = (int'(a[i]) + int'(b[i]) + int'(c[i])) >= 2;
    end
    return v;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 5; i++) m_cnt[i] = 0;
    m_st = 0; m_rv = 0; m_rc = 0; m_rts = 0;
    m_fat = 0; m_alm = 0; m_ts = 0;
    m_p = '{default: 0};
  endfunction

  function automatic logic [15:0] m_read(input logic [2:0] s);
    case (s)
      3'd5:    return {m_fat, m_rv, 6'b0, m_rc, m_st};
      3'd6:    return m_rts[15:0];
      3'd7:    return m_rts[31:16];
      default: return 16'(m_cnt[s]);
    endcase
  endfunction

  // One clock of the model, evaluated with the inputs about to be sampled.
  task automatic tick();
    exp_t     e;
    bit [4:0] ev;
    bit       unc;
    if (rst) begin
      m_reset();
      e = '{voted: '0, alarm: 0, fatal: 0, rd: '0};
    end else begin
      e.voted = vote(d0, d1, d2);
      e.rd = m_read(sel);
      ev[0] = !((m_p.l0 == m_p.l1) && (m_p.l1 == m_p.l2));
      ev[1] = m_p.mem;
      ev[2] = m_p.ecc;
      ev[3] = m_p.mult;
      ev[4] = m_p.cs;
      unc = (m_p.l0 != m_p.l1) && (m_p.l1 != m_p.l2)
         && (m_p.l0 != m_p.l2);
      if (m_p.clr) begin
        for (int i = 0; i < 5; i++) m_cnt[i] = 0;
        m_st = 0; m_rv = 0; m_rc = 0; m_rts = 0; m_fat = 0;
      end
      for (int i = 0; i < 5; i++) begin
        if (ev[i]) begin
          if (m_cnt[i] < 65535) m_cnt[i]++;
          m_st[i] = 1;
        end
        if (m_cnt[i] >= 8) m_fat = 1;
      end
      if (ev != 0 && !m_rv) begin
        m_rv = 1;
        m_rts = m_p.ts;
        for (int i = 4; i >= 0; i--) if (ev[i]) m_rc = 3'(i);
      end
      if (ev[4] || unc) m_fat = 1;
      if (ev != 0) m_alm = 1;
      else if (m_p.ack) m_alm = 0;
      e.alarm = m_alm;
      e.fatal = m_fat;
      m_p.l0 = d0; m_p.l1 = d1; m_p.l2 = d2;
      m_p.mem = |mem; m_p.ecc = |ecc; m_p.mult = |mult;
      m_p.cs = cs; m_p.clr = clr; m_p.ack = ack;
      m_p.ts = m_ts;
      m_ts = m_ts + 1;
    end
    q.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("voted", 64'(voted), 64'(e.voted));
        chk("alarm", 64'(alarm), 64'(e.alarm));
        chk("fatal", 64'(fatal), 64'(e.fatal));
        chk("rd", 64'(rd), 64'(e.rd));
      end
    end
  end

  task automatic idle_in();
    d0 = '0; d1 = '0; d2 = '0;
    mem = '0; ecc = '0; mult = '0;
    cs = 0; clr = 0; ack = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    idle_in();
    sel = 0;
    tick();
    tick();
    rst = 0;
  endtask

  initial begin
    logic [32:0] b;
    int k;
    @(negedge clk);
    do_reset();

    d0 = 33'h1_0000_0005; d1 = 33'h1_0000_0005; d2 = 33'h0_0000_0005;
    tick();
    chk("voted_maj", 64'(voted), 64'h1_0000_0005);
    idle_in();
    tick();
    chk("div_alarm", 64'(alarm), 64'd1);
    sel = 3'd0;
    tick();
    chk("div_cnt", 64'(rd), 64'd1);

    do_reset();
    d0 = 33'd1; d1 = 33'd2; d2 = 33'd3;
    tick();
    idle_in();
    tick();
    chk("unc_fatal", 64'(fatal), 64'd1);
    sel = 3'd5;
    tick();
    chk("unc_stat0", 64'(rd[0]), 64'd1);
    chk("unc_cls", 64'(rd[7:5]), 64'd0);

    do_reset();
    while (m_ts != 100) tick();
    ecc = 3'b010; mult = 9'h100;
    tick();
    idle_in();
    tick();
    sel = 3'd6; tick();
    chk("ts100", 64'(rd), 64'd100);
    sel = 3'd5; tick();
    chk("rec_cls2", 64'(rd[7:5]), 64'd2);
    sel = 3'd2; tick();
    chk("ecc_cnt", 64'(rd), 64'd1);
    sel = 3'd3; tick();
    chk("mult_cnt", 64'(rd), 64'd1);

    do_reset();
    cs = 1; tick();
    cs = 0; tick();
    ack = 1; cs = 1; tick();
    cs = 0; tick();
    chk("ack_ev_hold", 64'(alarm), 64'd1);
    ack = 0; tick();
    chk("ack_alone", 64'(alarm), 64'd0);

    do_reset();
    mem = 15'h0400;
    sel = 3'd1;
    for (int i = 0; i < 70000; i++) tick();
    chk("mem_fatal", 64'(fatal), 64'd1);
    mem = '0; tick();
    chk("mem_sat", 64'(rd), 64'hFFFF);

    ecc = 3'b001; tick();
    ecc = '0; tick();
    clr = 1; mem = 15'h0001; tick();
    clr = 0; mem = '0; tick();
    sel = 3'd1; tick();
    chk("clr_mem", 64'(rd), 64'd1);
    sel = 3'd5; tick();
    chk("clr_status", 64'(rd[4:0]), 64'b00010);
    chk("clr_fatal", 64'(fatal), 64'd0);
    sel = 3'd2; tick();
    chk("clr_ecc", 64'(rd), 64'd0);

    do_reset();
    for (int i = 0; i < 4000; i++) begin
      b = {1'($urandom_range(0, 1)), $urandom()};
      k = $urandom_range(0, 9);
      d0 = b; d1 = b; d2 = b;
      if (k == 7) d1 = b ^ 33'({$urandom()} | 1);
      if (k == 8) d0 = ~b;
      if (k == 9) begin d1 = b ^ 33'd1; d2 = b ^ 33'd2; end
      mem  = ($urandom_range(0, 9) == 0) ? 15'($urandom()) : '0;
      ecc  = ($urandom_range(0, 9) == 0) ? 3'($urandom()) : '0;
      mult = ($urandom_range(0, 9) == 0) ? 9'($urandom()) : '0;
      cs   = ($urandom_range(0, 39) == 0);
      clr  = ($urandom_range(0, 63) == 0);
      ack  = ($urandom_range(0, 3) == 0);
      sel  = 3'($urandom_range(0, 7));
      rst  = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 0;
    idle_in();
    tick();
    @(posedge clk);
    #2;
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
